// File: rtl/uart_log_arbiter.sv
// Line-atomic arbiter sharing one byte-wide log sink between a secure and a
// non-secure UART transmit path, with a hold timeout against unterminated lines.
module uart_log_arbiter #(
    parameter logic [7:0] EOL_CHAR = 8'h0A,
    parameter int          MAX_HOLD = 256,
    parameter int          CNT_W    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    output logic       s_ready_o,
    input  logic       ns_valid_i,
    input  logic [7:0] ns_data_i,
    output logic       ns_ready_o,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    output logic       tx_src_o,
    input  logic       tx_ready_i,
    output logic       hold_timeout_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_S  = 2'b01,
        GNT_NS = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    function automatic logic is_eol(input logic [7:0] b);
        return (b == EOL_CHAR);
    endfunction

    state_t           state_r;
    logic             last_grant_r;   // 0 = secure was last owner, 1 = non-secure
    logic [CNT_W-1:0] hold_cnt_r;
    logic             hold_timeout_r;
    logic             tx_valid_r;
    logic [7:0]       tx_data_r;
    logic             tx_src_r;

    logic             own_valid_s;
    logic [7:0]       own_data_s;
    logic             other_valid_s;
    logic             granted_s;
    logic             is_ns_s;
    logic             slot_open_s;
    logic             eol_accept_s;
    logic             timeout_s;
    logic             own_ready_s;
    logic             accept_s;
    logic             pick_valid_s;
    logic             pick_ns_s;

    // Route the currently granted source onto a common request view
    always_comb begin
        own_valid_s   = 1'b0;
        own_data_s    = 8'h00;
        other_valid_s = 1'b0;
        granted_s     = 1'b0;
        is_ns_s       = 1'b0;
        case (state_r)
            GNT_S: begin
                own_valid_s   = s_valid_i;
                own_data_s    = s_data_i;
                other_valid_s = ns_valid_i;
                granted_s     = 1'b1;
                is_ns_s       = 1'b0;
            end
            GNT_NS: begin
                own_valid_s   = ns_valid_i;
                own_data_s    = ns_data_i;
                other_valid_s = s_valid_i;
                granted_s     = 1'b1;
                is_ns_s       = 1'b1;
            end
            default: begin
                own_valid_s   = 1'b0;
                own_data_s    = 8'h00;
                other_valid_s = 1'b0;
                granted_s     = 1'b0;
                is_ns_s       = 1'b0;
            end
        endcase
    end

    // Handshake qualification; an EOL accepted this cycle pre-empts the timeout
    always_comb begin
        slot_open_s  = ~tx_valid_r | tx_ready_i;
        eol_accept_s = granted_s & slot_open_s & own_valid_s & is_eol(own_data_s);
        timeout_s    = granted_s & (hold_cnt_r == HOLD_LIMIT) & other_valid_s & ~eol_accept_s;
        own_ready_s  = granted_s & slot_open_s & ~timeout_s;
        accept_s     = own_ready_s & own_valid_s;
    end

    // Round-robin choice between pending sources while idle
    always_comb begin
        pick_valid_s = 1'b0;
        pick_ns_s    = 1'b0;
        if (s_valid_i && ns_valid_i) begin
            pick_valid_s = 1'b1;
            pick_ns_s    = ~last_grant_r;
        end else if (s_valid_i) begin
            pick_valid_s = 1'b1;
            pick_ns_s    = 1'b0;
        end else if (ns_valid_i) begin
            pick_valid_s = 1'b1;
            pick_ns_s    = 1'b1;
        end else begin
            pick_valid_s = 1'b0;
            pick_ns_s    = 1'b0;
        end
    end

    // Grant FSM, hold counter and timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            last_grant_r   <= 1'b1;
            hold_cnt_r     <= CNT_ZERO;
            hold_timeout_r <= 1'b0;
        end else begin
            hold_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    hold_cnt_r <= CNT_ZERO;
                    if (pick_valid_s) begin
                        state_r <= pick_ns_s ? GNT_NS : GNT_S;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT_S, GNT_NS: begin
                    if (eol_accept_s) begin
                        state_r      <= IDLE;
                        last_grant_r <= is_ns_s;
                        hold_cnt_r   <= CNT_ZERO;
                    end else if (timeout_s) begin
                        state_r        <= IDLE;
                        last_grant_r   <= is_ns_s;
                        hold_cnt_r     <= CNT_ZERO;
                        hold_timeout_r <= 1'b1;
                    end else if (hold_cnt_r != HOLD_LIMIT) begin
                        hold_cnt_r <= hold_cnt_r + CNT_ONE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    hold_cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Output register: load on accept, drain when the sink takes the byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_src_r   <= 1'b0;
        end else if (accept_s) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= own_data_s;
            tx_src_r   <= is_ns_s;
        end else if (tx_ready_i) begin
            tx_valid_r <= 1'b0;
        end else begin
            tx_valid_r <= tx_valid_r;
        end
    end

    assign s_ready_o      = own_ready_s & (state_r == GNT_S);
    assign ns_ready_o     = own_ready_s & (state_r == GNT_NS);
    assign tx_valid_o     = tx_valid_r;
    assign tx_data_o      = tx_data_r;
    assign tx_src_o       = tx_src_r;
    assign hold_timeout_o = hold_timeout_r;

endmodule

// File: doc/uart_log_arbiter.md
Name: uart_log_arbiter

Overview:
- Shares one byte-wide log sink between two UART transmit sources: the secure UART and the non-secure UART.
- Arbitration is line-atomic. Once a source is granted, it keeps the sink until it sends an end-of-line byte, so secure and non-secure console text never interleave mid-line.
- A hold timeout stops a source that never terminates its line from starving the other.
- Sits between the two UART tx byte paths and the shared console/log sink at SoC top level.

Parameters:
- EOL_CHAR, 8'h0A, byte value that ends a line and releases the grant.
- MAX_HOLD, 256, cycles a grant may last without EOL before it is revoked (only when the other source is waiting).
- CNT_W, 9, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s_valid_i  in  1  secure source byte valid
- s_data_i  in  8  secure source byte
- s_ready_o  out  1  secure byte accepted when s_valid_i & s_ready_o
- ns_valid_i  in  1  non-secure source byte valid
- ns_data_i  in  8  non-secure source byte
- ns_ready_o  out  1  non-secure byte accepted when ns_valid_i & ns_ready_o
- tx_valid_o  out  1  sink byte valid (registered)
- tx_data_o  out  8  sink byte (registered)
- tx_src_o  out  1  source of the byte in tx_data_o: 0 = secure, 1 = non-secure
- tx_ready_i  in  1  sink accepts when tx_valid_o & tx_ready_i
- hold_timeout_o  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset: FSM=IDLE, last_grant=1 (secure wins the first tie), hold_cnt=0. All outputs 0. A byte held in the output register is discarded; there is no partial-line recovery.
- FSM states: IDLE, GNT_S, GNT_NS.
  - IDLE, only s_valid_i -> GNT_S.
  - IDLE, only ns_valid_i -> GNT_NS.
  - IDLE, both valid -> grant the source other than last_grant.
  - IDLE, none valid -> stay in IDLE.
  - The grant takes effect the cycle after the request; ready is never asserted in IDLE.
- Ready: in GNT_x, x_ready_o = (~tx_valid_o | tx_ready_i). The other source's ready = 0.
- Output register:
  - On accept, it loads the byte and tx_src_o and sets tx_valid_o=1 on the next edge (1-cycle latency).
  - If the sink consumes and no new byte is accepted in the same cycle, tx_valid_o clears.
  - Full throughput is 1 byte/cycle while tx_ready_i=1.
  - tx_data_o and tx_src_o are stable while tx_valid_o & ~tx_ready_i.
- EOL release: on acceptance of a byte == EOL_CHAR in GNT_x -> IDLE, last_grant=x. The EOL byte itself is forwarded.
- Hold counter:
  - Cleared on entry to GNT_x.
  - Increments each cycle in GNT_x and saturates at MAX_HOLD.
  - When hold_cnt == MAX_HOLD and the other source's valid is 1 -> IDLE, last_grant=x, hold_timeout_o=1 for one cycle.
  - If the other source is idle, the grant persists indefinitely at the saturated count.
  - No byte is accepted in the cycle the timeout fires (ready forced 0).
- Simultaneous EOL accept and timeout in the same cycle: EOL release wins, hold_timeout_o=0.
- Source deasserting valid mid-line: the grant is kept. Only EOL or timeout releases it.
- Sink stall: the counter keeps running. A timeout during a stall revokes the grant, but the byte already in the output register is still delivered.
- IDLE with tx_valid_o=1: the pending byte drains normally. The new grant may be issued in the same cycle.
- Data is never modified or dropped except by reset.

Test Plan:
- Secure alone: send "AB\n" (8'h41, 8'h42, 8'h0A), tx_ready_i=1 -> tx_data_o=41, 42, 0A on consecutive cycles, tx_src_o=0. FSM returns to IDLE after the 0A accept.
- Contention: both sources valid from reset; secure sends "X\n", non-secure sends "Y\n" -> output 58, 0A (src 0), then 59, 0A (src 1). Non-secure ready stays 0 throughout the secure line.
- Timeout: MAX_HOLD=8. Secure sends 41 and never EOL; non-secure valid at cycle 2 -> hold_timeout_o pulses 8 cycles after GNT_S entry, then non-secure bytes flow with tx_src_o=1.
- No contention: secure holds without EOL for 50 cycles, MAX_HOLD=8, ns_valid_i=0 -> no timeout pulse, grant retained.
- Backpressure: tx_ready_i=0 for 5 cycles with the byte 41 pending -> tx_valid_o=1 and tx_data_o=41 stable, s_ready_o=0. Resume -> 41 accepted once, no duplication.
- Reset mid-line: assert rst during GNT_NS with tx_valid_o=1 -> all outputs 0 asynchronously. After release, a tie grants secure first.
